minterm_scanner: RTL and testbench

MINTERM_SCANNER -- requirements
Module: minterm_scanner

---
 rtl/minterm_scanner.sv | 133 +++++++++++++
 tb/tb_minterm_scanner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/minterm_scanner.sv
// Walks all 32 input vectors of a 5-input function, captures its response and
// compares it against a golden truth table latched at scan start.
module minterm_scanner #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        f_in,
    input  logic [31:0] expected,
    output logic        X,
    output logic        Y,
    output logic        Z,
    output logic        K,
    output logic        M,
    output logic        busy,
    output logic        done,
    output logic [31:0] truth_table,
    output logic [5:0]  ones_count,
    output logic        mismatch,
    output logic [4:0]  first_mismatch_idx
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [4:0]  r_idx;
    logic [3:0]  r_settle;
    logic [31:0] r_expected;
    logic [31:0] r_truthTable;
    logic [5:0]  r_onesCount;
    logic        r_mismatch;
    logic [4:0]  r_firstMismatchIdx;
    logic        w_settleDone;

    assign w_settleDone = (r_settle == 4'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        busy            = 1'b0;
        done            = 1'b0;
        {X, Y, Z, K, M} = 5'd0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = DRIVE;
                end
            end
            DRIVE: begin
                busy            = 1'b1;
                {X, Y, Z, K, M} = r_idx;
                if (w_settleDone) begin
                    w_nextState = SAMPLE;
                end
            end
            SAMPLE: begin
                busy            = 1'b1;
                {X, Y, Z, K, M} = r_idx;
                w_nextState     = (r_idx == 5'd31) ? DONE : DRIVE;
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Results are only touched at scan start and in SAMPLE, so they hold after done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx              <= 5'd0;
            r_settle           <= 4'd0;
            r_expected         <= 32'd0;
            r_truthTable       <= 32'd0;
            r_onesCount        <= 6'd0;
            r_mismatch         <= 1'b0;
            r_firstMismatchIdx <= 5'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_expected         <= expected;
                        r_truthTable       <= 32'd0;
                        r_onesCount        <= 6'd0;
                        r_mismatch         <= 1'b0;
                        r_firstMismatchIdx <= 5'd0;
                        r_idx              <= 5'd0;
                        r_settle           <= 4'd0;
                    end
                end
                DRIVE: begin
                    r_settle <= w_settleDone ? 4'd0 : r_settle + 4'd1;
                end
                SAMPLE: begin
                    r_truthTable[r_idx] <= f_in;
                    r_onesCount         <= r_onesCount + {5'd0, f_in};
                    if ((f_in != r_expected[r_idx]) && !r_mismatch) begin
                        r_mismatch         <= 1'b1;
                        r_firstMismatchIdx <= r_idx;
                    end
                    if (r_idx != 5'd31) begin
                        r_idx <= r_idx + 5'd1;
                    end
                end
                DONE: begin
                    r_idx <= 5'd0;
                end
                default: r_idx <= 5'd0;
            endcase
        end
    end

    assign truth_table        = r_truthTable;
    assign ones_count         = r_onesCount;
    assign mismatch           = r_mismatch;
    assign first_mismatch_idx = r_firstMismatchIdx;

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed scoreboard bench for minterm_scanner: one instance with the default
// settle time and one with SETTLE_CYCLES=3.
module tb_minterm_scanner;

    typedef struct {
        logic [31:0] truth;
        logic [5:0]  ones;
        logic        mm;
        logic [4:0]  first;
        int          cycles;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1;
    logic        start3;
    logic [31:0] expected;
    int          mode;
    int          sel;
    int          checkCount;
    int          passCount;
    int          failCount;
    exp_t        sbQ[$];

    logic        x1, y1, z1, k1, m1, busy1, done1, mm1, f1;
    logic [31:0] tt1;
    logic [5:0]  oc1;
    logic [4:0]  fm1;
    logic        x3, y3, z3, k3, m3, busy3, done3, mm3, f3;
    logic [31:0] tt3;
    logic [5:0]  oc3;
    logic [4:0]  fm3;

    always #5 clk = ~clk;

    // Function under test: 0 = tied low, 1 = M, 2 = X, 3 = X&Y&Z&K&M.
    function automatic logic fModel(input int md, input logic [4:0] v);
        case (md)
            1:       return v[0];
            2:       return v[4];
            3:       return &v;
            default: return 1'b0;
        endcase
    endfunction

    assign f1 = fModel(mode, {x1, y1, z1, k1, m1});
    assign f3 = fModel(mode, {x3, y3, z3, k3, m3});

    minterm_scanner dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1), .expected(expected),
        .X(x1), .Y(y1), .Z(z1), .K(k1), .M(m1), .busy(busy1), .done(done1),
        .truth_table(tt1), .ones_count(oc1), .mismatch(mm1), .first_mismatch_idx(fm1)
    );

    minterm_scanner #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f3), .expected(expected),
        .X(x3), .Y(y3), .Z(z3), .K(k3), .M(m3), .busy(busy3), .done(done3),
        .truth_table(tt3), .ones_count(oc3), .mismatch(mm3), .first_mismatch_idx(fm3)
    );

    logic [4:0]  selVec;
    logic        selBusy, selDone, selMm;
    logic [31:0] selTt;
    logic [5:0]  selOc;
    logic [4:0]  selFm;
    assign selVec  = (sel == 3) ? {x3, y3, z3, k3, m3} : {x1, y1, z1, k1, m1};
    assign selBusy = (sel == 3) ? busy3 : busy1;
    assign selDone = (sel == 3) ? done3 : done1;
    assign selTt   = (sel == 3) ? tt3 : tt1;
    assign selOc   = (sel == 3) ? oc3 : oc1;
    assign selMm   = (sel == 3) ? mm3 : mm1;
    assign selFm   = (sel == 3) ? fm3 : fm1;

    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Builds the expected result from the function definition, queues it, then
    // pulses start so that the accepting edge is the next rising edge.
    task automatic applyStimulus(input int which, input int md, input logic [31:0] expv,
                                 input int settle, input bit push);
        exp_t e;
        logic b;
        e.truth = 32'd0;
        e.ones  = 6'd0;
        e.mm    = 1'b0;
        e.first = 5'd0;
        for (int i = 0; i < 32; i++) begin
            b          = fModel(md, 5'(i));
            e.truth[i] = b;
            e.ones     = e.ones + {5'd0, b};
            if ((b != expv[i]) && !e.mm) begin
                e.mm    = 1'b1;
                e.first = 5'(i);
            end
        end
        e.cycles = 32 * (settle + 1) + 1;
        if (push) sbQ.push_back(e);
        sel      = which;
        mode     = md;
        expected = expv;
        @(negedge clk);
        if (which == 3) start3 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done, optionally re-pulsing
    // start and disturbing expected while the scan is at idx 10.
    task automatic waitDone(input int limit, input int pokeCycle,
                            output int doneCycle, output int held5);
        doneCycle = -1;
        held5     = 0;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (selBusy && selVec == 5'd5) held5++;
            if (c == pokeCycle) begin
                expectEq("idxAtPoke", {27'd0, selVec}, 32'd10);
                start1   = 1'b1;
                expected = 32'hAAAA_AAAA;
            end
            if (c == pokeCycle + 1) start1 = 1'b0;
            if (selDone) begin
                doneCycle = c;
                break;
            end
        end
    endtask

    task automatic checkOutput(input int doneCycle);
        exp_t e;
        e = sbQ.pop_front();
        expectEq("doneCycle", doneCycle, e.cycles);
        expectEq("truthTable", selTt, e.truth);
        expectEq("onesCount", {26'd0, selOc}, {26'd0, e.ones});
        expectEq("mismatch", {31'd0, selMm}, {31'd0, e.mm});
        expectEq("firstMismatchIdx", {27'd0, selFm}, {27'd0, e.first});
        @(negedge clk);
        expectEq("donePulseEnd", {31'd0, selDone}, 32'd0);
        expectEq("idleVector", {27'd0, selVec}, 32'd0);
        expectEq("truthTableHeld", selTt, e.truth);
    endtask

    task automatic checkAllZero(input string tag);
        expectEq({tag, "Truth"}, tt1, 32'd0);
        expectEq({tag, "Ones"}, {26'd0, oc1}, 32'd0);
        expectEq({tag, "Mismatch"}, {31'd0, mm1}, 32'd0);
        expectEq({tag, "First"}, {27'd0, fm1}, 32'd0);
        expectEq({tag, "Busy"}, {31'd0, busy1}, 32'd0);
        expectEq({tag, "Done"}, {31'd0, done1}, 32'd0);
        expectEq({tag, "Vector"}, {27'd0, x1, y1, z1, k1, m1}, 32'd0);
    endtask

    initial begin
        int dc;
        int h5;
        int doneSeen;
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        rst_n      = 1'b0;
        start1     = 1'b0;
        start3     = 1'b0;
        expected   = 32'd0;
        mode       = 0;
        sel        = 1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        applyStimulus(1, 0, 32'h0000_0000, 1, 1'b1);
        waitDone(100, -10, dc, h5);
        checkOutput(dc);

        applyStimulus(1, 1, 32'hAAAA_AAAA, 1, 1'b1);
        waitDone(100, -10, dc, h5);
        checkOutput(dc);

        applyStimulus(1, 2, 32'hFFFF_0000, 1, 1'b1);
        waitDone(100, -10, dc, h5);
        checkOutput(dc);

        applyStimulus(1, 3, 32'h8000_0000, 1, 1'b1);
        waitDone(100, -10, dc, h5);
        checkOutput(dc);

        applyStimulus(1, 3, 32'h8000_0001, 1, 1'b1);
        waitDone(100, -10, dc, h5);
        checkOutput(dc);

        applyStimulus(1, 1, 32'hAAAA_AAAB, 1, 1'b1);
        waitDone(100, -10, dc, h5);
        checkOutput(dc);

        applyStimulus(1, 1, 32'h2AAA_AAAA, 1, 1'b1);
        waitDone(100, -10, dc, h5);
        checkOutput(dc);

        // Start re-pulsed at idx 10 with expected changed: must be ignored.
        applyStimulus(1, 1, 32'hAAAA_AAAB, 1, 1'b1);
        waitDone(100, 21, dc, h5);
        checkOutput(dc);
        doneSeen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done1) doneSeen++;
        end
        expectEq("noQueuedScan", doneSeen, 0);

        // Reset mid-scan at idx 20 aborts without a done pulse.
        applyStimulus(1, 1, 32'h0000_0000, 1, 1'b0);
        doneSeen = 0;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            if (done1) doneSeen++;
        end
        expectEq("idxAtAbort", {27'd0, x1, y1, z1, k1, m1}, 32'd20);
        rst_n = 1'b0;
        @(negedge clk);
        checkAllZero("abort");
        rst_n = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (done1) doneSeen++;
        end
        expectEq("noDoneAfterAbort", doneSeen, 0);

        applyStimulus(1, 1, 32'hAAAA_AAAA, 1, 1'b1);
        waitDone(100, -10, dc, h5);
        checkOutput(dc);

        applyStimulus(3, 1, 32'hAAAA_AAAA, 3, 1'b1);
        waitDone(200, -10, dc, h5);
        expectEq("settle3Hold", h5, 4);
        checkOutput(dc);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
